// File: rtl/clkgate_seq.sv
// clkgate_seq: sequencer for an array of clock-gate cells.
// Branches are turned on one at a time, at least GAP cycles apart. The next
// branch is picked round-robin. Each branch is gated again after IDLE
// consecutive cycles with neither req nor busy set.
//   clk       free-running ungated clock
//   rst       synchronous reset, active-high
//   req       per-branch clock request (level)
//   busy      per-branch activity; keeps a branch on the same way req does
//   force_on  test mode: enable every branch at once, no stagger, no idle gating
//   en        clock-gate E pins (registered)
//   ack       branch clock running and settled (registered)
//   n_on      number of branches with en high (registered)

// Per-branch FSM. The arbiter lives in the parent module.
//   grant   granted this cycle by the arbiter
//   pend    request pending (OFF/WAIT with req)
//   en_nxt  next-cycle value of en, used by the parent for n_on
module clkgate_seq_ch #(
  parameter int IDLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic busy,
  input  logic force_on,
  input  logic grant,
  output logic pend,
  output logic en_nxt,
  output logic en,
  output logic ack
);
  localparam int IW = $clog2(IDLE + 1);

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_ON     = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]    state, nxt;
  logic [IW-1:0] idle, idle_nxt;
  logic          stl, stl_nxt;   // set in the second SETTLE cycle
  logic          act;

  always_comb begin
    act      = req | busy;
    pend     = ((state == S_OFF) || (state == S_WAIT)) && req;
    nxt      = state;
    idle_nxt = '0;
    stl_nxt  = 1'b0;
    case (state)
      S_OFF, S_WAIT: begin
        if (force_on || grant) nxt = S_SETTLE;
        else if (req)          nxt = S_WAIT;
        else                   nxt = S_OFF;
      end
      S_SETTLE: begin
        stl_nxt = 1'b1;
        if (stl) nxt = S_ON;
      end
      S_ON: begin
        // force_on holds the idle count at zero, so ON is sticky.
        if (!force_on && !act) begin
          idle_nxt = (idle == IW'(IDLE)) ? idle : idle + IW'(1);
          if (idle == IW'(IDLE - 1)) nxt = S_DRAIN;
        end
      end
      // DRAIN always completes, even under new activity or force_on.
      S_DRAIN: nxt = S_OFF;
      default: nxt = S_OFF;
    endcase
    en_nxt = (nxt == S_SETTLE) || (nxt == S_ON) || (nxt == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OFF;
      idle  <= '0;
      stl   <= 1'b0;
      en    <= 1'b0;
      ack   <= 1'b0;
    end else begin
      state <= nxt;
      idle  <= idle_nxt;
      stl   <= stl_nxt;
      en    <= en_nxt;
      ack   <= (nxt == S_ON);
    end
  end
endmodule

module clkgate_seq #(
  parameter int N_CH = 4,
  parameter int GAP  = 4,
  parameter int IDLE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH-1:0]           busy,
  input  logic                      force_on,
  output logic [N_CH-1:0]           en,
  output logic [N_CH-1:0]           ack,
  output logic [$clog2(N_CH+1)-1:0] n_on
);
  localparam int PW = $clog2(N_CH);
  localparam int GW = $clog2(GAP + 1);
  localparam int NW = $clog2(N_CH + 1);

  logic [N_CH-1:0] pend, grant, en_nxt;
  logic [PW-1:0]   rr_ptr, gnt_idx, ptr_nxt;
  logic [GW-1:0]   gap_cnt;
  logic [NW-1:0]   pop;
  logic            found;
  int              k;

  clkgate_seq_ch #(.IDLE(IDLE)) u_ch [N_CH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .busy     (busy),
    .force_on (force_on),
    .grant    (grant),
    .pend     (pend),
    .en_nxt   (en_nxt),
    .en       (en),
    .ack      (ack)
  );

  // Round-robin: first pending channel at or after rr_ptr, wrapping.
  // force_on bypasses the arbiter; every OFF/WAIT channel starts at once.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    if (!force_on && (gap_cnt == '0)) begin
      for (int i = 0; i < N_CH; i++) begin
        k = int'(rr_ptr) + i;
        if (k >= N_CH) k = k - N_CH;
        if (!found && pend[k]) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          gnt_idx  = PW'(k);
        end
      end
    end
    ptr_nxt = (gnt_idx == PW'(N_CH - 1)) ? '0 : gnt_idx + PW'(1);
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) pop = pop + NW'(en_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      gap_cnt <= '0;
      n_on    <= '0;
    end else begin
      if (force_on) begin
        gap_cnt <= GW'(GAP - 1);
      end else if (found) begin
        gap_cnt <= GW'(GAP - 1);
        rr_ptr  <= ptr_nxt;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      n_on <= pop;
    end
  end
endmodule

// File: tb/tb_clkgate_seq.sv
// Directed bench for clkgate_seq (N_CH=4, GAP=4, IDLE=16).
// Cycle c is the window just after posedge c: inputs set there are sampled
// at posedge c+1, and the outputs read there are the registered results.
module tb_clkgate_seq;
  logic       clk;
  logic       rst;
  logic [3:0] req, busy;
  logic       force_on;
  logic [3:0] en, ack;
  logic [2:0] n_on;

  int n_tests = 0;
  int n_fail  = 0;

  clkgate_seq #(.N_CH(4), .GAP(4), .IDLE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .busy     (busy),
    .force_on (force_on),
    .en       (en),
    .ack      (ack),
    .n_on     (n_on)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_en, input logic [3:0] e_ack);
    check({tag, ".en"},   32'(en),   32'(e_en));
    check({tag, ".ack"},  32'(ack),  32'(e_ack));
    check({tag, ".n_on"}, 32'(n_on), 32'($countones(e_en)));
  endtask

  // Reset for two cycles with req all-ones, then release with req low.
  task automatic do_reset();
    rst = 1'b1; req = 4'hF; busy = 4'h0; force_on = 1'b0;
    tick(); chk_out("rst0", 4'h0, 4'h0);
    tick(); chk_out("rst1", 4'h0, 4'h0);
    rst = 1'b0; req = 4'h0;
    tick(); chk_out("rst_after", 4'h0, 4'h0);
  endtask

  initial begin
    logic [3:0] e_en, e_ack;
    rst = 1'b1; req = 4'hF; busy = 4'h0; force_on = 1'b0;

    // 1. reset
    do_reset();

    // 2. single request on channel 0
    tick();
    req = 4'b0001;
    tick(); chk_out("single.c1", 4'b0001, 4'b0000);
    tick(); chk_out("single.c2", 4'b0001, 4'b0000);
    tick(); chk_out("single.c3", 4'b0001, 4'b0001);

    // 3. all four request together: grants 4 cycles apart, in order 0..3
    do_reset();
    req = 4'hF;
    for (int c = 1; c <= 16; c++) begin
      tick();
      e_en = '0; e_ack = '0;
      for (int i = 0; i < 4; i++) begin
        if (c >= 1 + 4 * i) e_en[i]  = 1'b1;
        if (c >= 3 + 4 * i) e_ack[i] = 1'b1;
      end
      chk_out($sformatf("stagger.c%0d", c), e_en, e_ack);
    end

    // 4a. channel 2 goes idle: ack falls after 16 cycles, en one cycle later
    req = 4'b1011;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 15) chk_out("idle.c15", 4'hF, 4'hF);
      if (c == 16) chk_out("idle.c16", 4'hF, 4'b1011);
      if (c == 17) chk_out("idle.c17", 4'b1011, 4'b1011);
      if (c == 18) chk_out("idle.c18", 4'b1011, 4'b1011);
    end
    // channel 2 requests again
    req = 4'hF;
    tick(); chk_out("regrant2.c1", 4'hF, 4'b1011);
    tick();
    tick(); chk_out("regrant2.c3", 4'hF, 4'hF);

    // 4b. busy pulse 10 cycles into the idle run restarts the count
    req = 4'b1011;
    for (int c = 1; c <= 28; c++) begin
      tick();
      busy = (c == 10) ? 4'b0100 : 4'b0000;
      if (c == 20) chk_out("busy.c20", 4'hF, 4'hF);
      if (c == 26) chk_out("busy.c26", 4'hF, 4'hF);
      if (c == 27) chk_out("busy.c27", 4'hF, 4'b1011);
      if (c == 28) chk_out("busy.c28", 4'b1011, 4'b1011);
    end

    // 5. channel 1 re-requests in its DRAIN cycle: en low for one cycle only
    req = 4'b1001;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 15) chk_out("drain.c15", 4'b1011, 4'b1011);
      if (c == 16) begin
        chk_out("drain.c16", 4'b1011, 4'b1001);
        req = 4'b1011;
      end
      if (c == 17) chk_out("drain.c17", 4'b1001, 4'b1001);
      if (c == 18) chk_out("drain.c18", 4'b1011, 4'b1001);
      if (c == 19) chk_out("drain.c19", 4'b1011, 4'b1001);
      if (c == 20) chk_out("drain.c20", 4'b1011, 4'b1011);
    end

    // 6a. force_on: all branches at once, no idle gating while held
    do_reset();
    force_on = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 1)  chk_out("force.c1",  4'hF, 4'h0);
      if (c == 2)  chk_out("force.c2",  4'hF, 4'h0);
      if (c == 3)  chk_out("force.c3",  4'hF, 4'hF);
      if (c == 26) chk_out("force.c26", 4'hF, 4'hF);
    end
    // force_on falls: idle count starts from zero
    force_on = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 15) chk_out("unforce.c15", 4'hF, 4'hF);
      if (c == 16) chk_out("unforce.c16", 4'hF, 4'h0);
      if (c == 17) chk_out("unforce.c17", 4'h0, 4'h0);
    end

    // 6b. reset while all branches are in SETTLE
    force_on = 1'b1;
    tick(); chk_out("midrst.settle", 4'hF, 4'h0);
    rst = 1'b1; force_on = 1'b0;
    tick(); chk_out("midrst.rst", 4'h0, 4'h0);
    rst = 1'b0;
    tick(); chk_out("midrst.after", 4'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
